// File: rtl/axi4_pkg.sv
// Shared AXI4 types and helpers for the burst slaves.
//   burst_t    : AxBURST encodings
//   resp_t     : xRESP encodings
//   wr_state_t : write-slave FSM states
//   size_ok()  : true when a beat of 2**size bytes fits the data bus
package axi4_pkg;

    typedef enum logic [1:0] {
        BurstFixed = 2'b00,
        BurstIncr  = 2'b01,
        BurstWrap  = 2'b10,
        BurstRsvd  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExokay = 2'b01,
        RespSlverr = 2'b10,
        RespDecerr = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StResp
    } wr_state_t;

    function automatic logic size_ok(input logic [2:0] size, input int unsigned data_bytes);
        return (32'd1 << size) <= data_bytes;
    endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-beat address for an AXI4 burst.
// Ports:
//   addr_i      : current beat address
//   size_i      : log2 bytes per beat
//   len_i       : beats minus one (sets the WRAP container)
//   burst_i     : FIXED / INCR / WRAP
//   next_addr_o : address of the following beat
module axi4_burst_addr_gen import axi4_pkg::*; #(
    parameter int unsigned AddrWidth = 8
) (
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [2:0]           size_i,
    input  logic [7:0]           len_i,
    input  logic [1:0]           burst_i,
    output logic [AddrWidth-1:0] next_addr_o
);

    logic [AddrWidth-1:0] bytes;
    logic [AddrWidth-1:0] incr;
    logic [AddrWidth-1:0] mask;

    always_comb begin
        bytes = AddrWidth'(1) << size_i;
        incr  = addr_i + bytes;
        // WRAP container is bytes*(len+1); mask selects the offset inside it
        mask  = (bytes * AddrWidth'({1'b0, len_i} + 9'd1)) - AddrWidth'(1);
        case (burst_i)
            BurstFixed: next_addr_o = addr_i;
            BurstWrap:  next_addr_o = (addr_i & ~mask) | (incr & mask);
            default:    next_addr_o = incr;
        endcase
    end

endmodule

// File: rtl/axi4_wr_burst_slave.sv
// AXI4 write-burst slave: accepts one AW burst at a time, turns each W beat into a
// registered single-beat write on the mem_* port and returns one B response per burst.
// Ports:
//   aclk_i / areset_i        : clock, asynchronous active-high reset
//   aw*_i / awready_o        : write-address channel
//   w*_i  / wready_o         : write-data channel (wuser_i is ignored)
//   bvalid_o, bresp_o, bid_o, buser_o / bready_i : write-response channel
//   mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o : registered memory write port
// Optional (macro AXI4_WR_SLV_STATS_EN): stat_bursts_o / stat_errors_o saturating counters.
module axi4_wr_burst_slave import axi4_pkg::*; #(
    parameter int unsigned DATA_BYTES    = 4,
    parameter int unsigned ADDR_BYTES    = 1,
    parameter int unsigned NUM_ID_BITS   = 4,
    parameter int unsigned NUM_USER_BITS = 4
) (
    input  logic                       aclk_i,
    input  logic                       areset_i,
    input  logic                       awvalid_i,
    output logic                       awready_o,
    input  logic [ADDR_BYTES*8-1:0]    awaddr_i,
    input  logic [7:0]                 awlen_i,
    input  logic [2:0]                 awsize_i,
    input  logic [1:0]                 awburst_i,
    input  logic [NUM_ID_BITS-1:0]     awid_i,
    input  logic [NUM_USER_BITS-1:0]   awuser_i,
    input  logic                       wvalid_i,
    output logic                       wready_o,
    input  logic [DATA_BYTES*8-1:0]    wdata_i,
    input  logic [DATA_BYTES-1:0]      wstrb_i,
    input  logic                       wlast_i,
    input  logic [NUM_USER_BITS-1:0]   wuser_i,
    output logic                       bvalid_o,
    input  logic                       bready_i,
    output logic [1:0]                 bresp_o,
    output logic [NUM_ID_BITS-1:0]     bid_o,
    output logic [NUM_USER_BITS-1:0]   buser_o,
`ifdef AXI4_WR_SLV_STATS_EN
    output logic [31:0]                stat_bursts_o,
    output logic [31:0]                stat_errors_o,
`endif
    output logic                       mem_we_o,
    output logic [ADDR_BYTES*8-1:0]    mem_addr_o,
    output logic [DATA_BYTES*8-1:0]    mem_wdata_o,
    output logic [DATA_BYTES-1:0]      mem_wstrb_o
);

    localparam int unsigned AW = ADDR_BYTES * 8;

    wr_state_t                state_q, state_d;
    logic                     rst_done_q;
    logic [AW-1:0]            addr_q, addr_d, next_addr;
    logic [7:0]               len_q, len_d, beat_q, beat_d;
    logic [2:0]               size_q, size_d;
    logic [1:0]               burst_q, burst_d;
    logic [NUM_ID_BITS-1:0]   id_q, id_d;
    logic [NUM_USER_BITS-1:0] user_q, user_d;
    logic                     err_q, err_d;
    logic                     nowr_q, nowr_d;   // burst is illegal: suppress every write
    logic                     mem_we_d;
    logic [AW-1:0]            mem_addr_d;
    logic [DATA_BYTES*8-1:0]  mem_wdata_d;
    logic [DATA_BYTES-1:0]    mem_wstrb_d;
    logic                     aw_hs, w_hs, b_hs, last_beat;

    logic unused_wuser;
    assign unused_wuser = ^wuser_i;

    axi4_burst_addr_gen #(
        .AddrWidth (AW)
    ) u_addr_gen (
        .addr_i      (addr_q),
        .size_i      (size_q),
        .len_i       (len_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr)
    );

    // awready held low until the first clock after reset release
    assign awready_o = rst_done_q && (state_q == StIdle);
    assign wready_o  = (state_q == StData);
    assign bvalid_o  = (state_q == StResp);
    assign bresp_o   = (bvalid_o && err_q) ? RespSlverr : RespOkay;
    assign bid_o     = bvalid_o ? id_q : '0;
    assign buser_o   = bvalid_o ? user_q : '0;

    assign aw_hs     = awvalid_i && awready_o;
    assign w_hs      = wvalid_i && wready_o;
    assign b_hs      = bvalid_o && bready_i;
    assign last_beat = (beat_q == len_q);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        beat_d      = beat_q;
        size_d      = size_q;
        burst_d     = burst_q;
        id_d        = id_q;
        user_d      = user_q;
        err_d       = err_q;
        nowr_d      = nowr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_o;
        mem_wdata_d = mem_wdata_o;
        mem_wstrb_d = mem_wstrb_o;
        unique case (state_q)
            StIdle: begin
                if (aw_hs) begin
                    addr_d  = awaddr_i;
                    len_d   = awlen_i;
                    size_d  = awsize_i;
                    burst_d = awburst_i;
                    id_d    = awid_i;
                    user_d  = awuser_i;
                    beat_d  = 8'd0;
                    nowr_d  = (awburst_i == BurstRsvd) || !size_ok(awsize_i, DATA_BYTES) ||
                              ((awburst_i == BurstWrap) && !(awlen_i inside {8'd1, 8'd3, 8'd7, 8'd15}));
                    err_d   = nowr_d;
                    state_d = StData;
                end
            end
            StData: begin
                if (w_hs) begin
                    mem_we_d    = !nowr_q;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata_i;
                    mem_wstrb_d = wstrb_i;
                    addr_d      = next_addr;
                    beat_d      = beat_q + 8'd1;
                    if (wlast_i != last_beat) err_d = 1'b1;
                    // burst length is set by awlen alone; wlast only feeds the error flag
                    if (last_beat) state_d = StResp;
                end
            end
            StResp: begin
                if (b_hs) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            state_q     <= StIdle;
            rst_done_q  <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            id_q        <= '0;
            user_q      <= '0;
            err_q       <= 1'b0;
            nowr_q      <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
        end else begin
            state_q     <= state_d;
            rst_done_q  <= 1'b1;
            addr_q      <= addr_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            id_q        <= id_d;
            user_q      <= user_d;
            err_q       <= err_d;
            nowr_q      <= nowr_d;
            mem_we_o    <= mem_we_d;
            mem_addr_o  <= mem_addr_d;
            mem_wdata_o <= mem_wdata_d;
            mem_wstrb_o <= mem_wstrb_d;
        end
    end

`ifdef AXI4_WR_SLV_STATS_EN
    logic [31:0] stat_bursts_q, stat_bursts_d, stat_errors_q, stat_errors_d;

    always_comb begin
        stat_bursts_d = stat_bursts_q;
        stat_errors_d = stat_errors_q;
        if (b_hs) begin
            if (stat_bursts_q != '1) stat_bursts_d = stat_bursts_q + 32'd1;
            if (err_q && (stat_errors_q != '1)) stat_errors_d = stat_errors_q + 32'd1;
        end
    end

    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            stat_bursts_q <= '0;
            stat_errors_q <= '0;
        end else begin
            stat_bursts_q <= stat_bursts_d;
            stat_errors_q <= stat_errors_d;
        end
    end

    assign stat_bursts_o = stat_bursts_q;
    assign stat_errors_o = stat_errors_q;
`endif

endmodule
